// File: rtl/shot_sched_pkg.sv
// rtl/shot_sched_pkg.sv - shared types, constants and helpers for the shot scheduler
// Purpose: FSM state encoding, owner encoding, coordinate width and a popcount
//          helper used by shot_scheduler.
// Ports:   none (package).
package shot_sched_pkg;

  localparam int COORD_W = 11;

  localparam logic OWNER_PLAYER = 1'b1;
  localparam logic OWNER_ALIEN  = 1'b0;

  typedef enum logic [1:0] {
    IDLE_ST   = 2'd0,
    ARB_ST    = 2'd1,
    LAUNCH_ST = 2'd2,
    HOLD_ST   = 2'd3
  } state_t;

  // Slot vectors are at most 8 wide; callers zero-extend into this helper.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/slot_pick.sv
// rtl/slot_pick.sv - lowest-set-bit priority encoder for free projectile slots
// Purpose: picks the lowest-index set bit of req as a one-hot vector.
// Ports:   req    - candidate (free) slot mask
//          onehot - lowest set bit of req, zero when req is zero
//          any    - req has at least one bit set
module slot_pick #(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0] req,
  output logic [NUM_SLOTS-1:0] onehot,
  output logic                 any
);

  // Two's-complement isolates the lowest set bit.
  assign onehot = req & (~req + NUM_SLOTS'(1));
  assign any    = |req;

endmodule

// File: rtl/shot_scheduler.sv
// rtl/shot_scheduler.sv - shares projectile movers between the player cannon and alien bombs
// Purpose: turns fire-key edges and alien drop requests into one-hot launch
//          pulses with spawn coordinates, enforcing per-owner shot limits and a
//          frame-based player cooldown.
// Ports:   clk, resetN (async, active-high despite the name)
//          startOfFrame, enable, fire_key, ship_x/ship_y      - player side
//          alien_req_valid/x/y -> alien_req_ready              - alien handshake
//          slot_active (from movers) -> launch, launch_is_player, spawn_x/y
//          player_shots, busy                                 - status
// Optional: SHOT_SCHED_STATS_EN adds grant_cnt / drop_cnt saturating counters.
module shot_scheduler
  import shot_sched_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int PLAYER_MAX      = 1,
  parameter int ALIEN_MAX       = 3,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int PLAYER_Y_OFS    = 33,
  parameter int HOLD_TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 enable,
  input  logic                 fire_key,
  input  logic [COORD_W-1:0]   ship_x,
  input  logic [COORD_W-1:0]   ship_y,
  input  logic                 alien_req_valid,
  input  logic [COORD_W-1:0]   alien_req_x,
  input  logic [COORD_W-1:0]   alien_req_y,
  output logic                 alien_req_ready,
  input  logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] launch,
  output logic                 launch_is_player,
  output logic [COORD_W-1:0]   spawn_x,
  output logic [COORD_W-1:0]   spawn_y,
  output logic [3:0]           player_shots,
  output logic                 busy
`ifdef SHOT_SCHED_STATS_EN
  ,
  output logic [15:0]          grant_cnt,
  output logic [15:0]          drop_cnt
`endif
);

  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam int HT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [HT_W-1:0]    HT_LAST = HT_W'(HOLD_TIMEOUT - 1);
  localparam logic [3:0]         PMAX    = 4'(PLAYER_MAX);
  localparam logic [3:0]         AMAX    = 4'(ALIEN_MAX);
  localparam logic [COORD_W-1:0] Y_OFS   = COORD_W'(PLAYER_Y_OFS);

  state_t               state;
  logic                 fire_q1, fire_q2, fire_pend;
  logic [CD_W-1:0]      cooldown;
  logic [HT_W-1:0]      hold_cnt;
  logic [NUM_SLOTS-1:0] owner, slot_oh, held, free_mask, pick_oh;
  logic                 pick_any, cur_player, last_player;
  logic [3:0]           alien_shots;
  logic                 fire_edge, cd_zero, player_elig, alien_elig;
  logic                 player_wins, grant, grant_player, in_launch;
  logic [COORD_W-1:0]   player_spawn_y;

  slot_pick #(.NUM_SLOTS(NUM_SLOTS)) u_pick (
    .req    (free_mask),
    .onehot (pick_oh),
    .any    (pick_any)
  );

  assign fire_edge   = fire_q1 & ~fire_q2;
  assign cd_zero     = (cooldown == '0);
  assign in_launch   = (state == LAUNCH_ST);
  // The granted slot stays reserved until its mover acknowledges or we give up.
  assign held        = (in_launch || state == HOLD_ST) ? slot_oh : '0;
  assign free_mask   = ~slot_active & ~held;
  assign alien_shots = popcount8(8'(slot_active & ~owner));

  assign player_elig  = fire_pend && cd_zero && (player_shots < PMAX) && pick_any;
  assign alien_elig   = alien_req_valid && (alien_shots < AMAX) && pick_any;
  // Contention alternates: the alien only wins a tie right after a player grant.
  assign player_wins  = player_elig && !(alien_elig && last_player);
  assign grant        = (state == ARB_ST) && enable && (player_elig || alien_elig);
  assign grant_player = grant && player_wins;

  assign player_spawn_y = (ship_y >= Y_OFS) ? (ship_y - Y_OFS) : '0;

  assign launch           = in_launch ? slot_oh : '0;
  assign launch_is_player = in_launch && (cur_player == OWNER_PLAYER);
  assign alien_req_ready  = in_launch && (cur_player == OWNER_ALIEN);
  assign busy             = in_launch || (state == HOLD_ST);

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state       <= IDLE_ST;
      slot_oh     <= '0;
      owner       <= '0;
      cur_player  <= OWNER_ALIEN;
      last_player <= 1'b0;
      hold_cnt    <= '0;
      spawn_x     <= '0;
      spawn_y     <= '0;
    end else begin
      case (state)
        IDLE_ST: begin
          if (enable) state <= ARB_ST;
        end
        ARB_ST: begin
          if (!enable) begin
            state <= IDLE_ST;
          end else if (grant) begin
            state   <= LAUNCH_ST;
            slot_oh <= pick_oh;
            if (player_wins) begin
              cur_player <= OWNER_PLAYER;
              owner      <= owner | pick_oh;
              spawn_x    <= ship_x;
              spawn_y    <= player_spawn_y;
            end else begin
              cur_player <= OWNER_ALIEN;
              owner      <= owner & ~pick_oh;
              spawn_x    <= alien_req_x;
              spawn_y    <= alien_req_y;
            end
          end
        end
        LAUNCH_ST: begin
          state       <= HOLD_ST;
          hold_cnt    <= '0;
          last_player <= cur_player;
        end
        HOLD_ST: begin
          if (!enable) begin
            state <= IDLE_ST;
          end else if (|(slot_active & slot_oh) || hold_cnt == HT_LAST) begin
            state <= ARB_ST;
          end else begin
            hold_cnt <= hold_cnt + HT_W'(1);
          end
        end
        default: state <= IDLE_ST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      fire_q1      <= 1'b0;
      fire_q2      <= 1'b0;
      fire_pend    <= 1'b0;
      cooldown     <= '0;
      player_shots <= 4'd0;
    end else begin
      fire_q1 <= fire_key;
      fire_q2 <= fire_q1;
      // Edges arriving while cooling down are discarded, not deferred.
      if (!enable || grant_player) fire_pend <= 1'b0;
      else if (fire_edge && cd_zero) fire_pend <= 1'b1;
      if (grant_player) cooldown <= CD_LOAD;
      else if (startOfFrame && !cd_zero) cooldown <= cooldown - CD_W'(1);
      player_shots <= popcount8(8'(slot_active & owner));
    end
  end

`ifdef SHOT_SCHED_STATS_EN
  logic        drop_edge, drop_frame;
  logic [16:0] drop_sum;

  assign drop_edge  = fire_edge && !cd_zero;
  assign drop_frame = startOfFrame && fire_pend && cd_zero && (player_shots < PMAX) && !pick_any;
  assign drop_sum   = {1'b0, drop_cnt} + 17'(drop_edge) + 17'(drop_frame);

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      grant_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      if (in_launch && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
